// File: rtl/mem_bist_pkg.sv
// Shared types and LFSR helpers for the Wishbone SRAM self-test master.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_REQ = 3'd1,
        ST_WR_GAP = 3'd2,
        ST_RD_REQ = 3'd3,
        ST_RD_GAP = 3'd4,
        ST_FIN    = 3'd5
    } bist_state_e;

    // Reflected form of x^32 + x^22 + x^2 + x + 1 for a right-shifting Galois LFSR.
    localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;
    localparam logic [31:0] LFSR_SAFE_SEED = 32'h0000_0001;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

    // The all-zero state is a lock-up state, so it is never loaded.
    function automatic logic [31:0] safe_seed(input logic [31:0] s);
        return (s == 32'h0000_0000) ? LFSR_SAFE_SEED : s;
    endfunction

endpackage

// File: rtl/mem_bist_lfsr.sv
// Pattern generator shared by the write and read phases; reloading the seed
// replays the exact sequence for comparison.
module mem_bist_lfsr
    import mem_bist_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        step_i,
    output logic [31:0] value_o
);

    logic [31:0] value_q;

    // LFSR state: load wins over step.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            value_q <= 32'h0000_0000;
        end else if (load_i) begin
            value_q <= seed_i;
        end else if (step_i) begin
            value_q <= lfsr_next(value_q);
        end else begin
            value_q <= value_q;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/mem_bist_wb.sv
// Wishbone master self-test: writes an LFSR pattern to WORDS words, reads it
// back, and reports mismatches, first failing address and ack timeout.
module mem_bist_wb
    import mem_bist_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int unsigned WORDS    = 256,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic [31:0] seed_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [15:0] err_cnt_o,
    output logic [31:0] first_err_adr_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    localparam int unsigned      IDX_W    = $clog2(WORDS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [15:0]      WAIT_LIM = 16'(TIMEOUT - 1);

    bist_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      wait_q, wait_d;
    logic [15:0]      err_q, err_d;
    logic [31:0]      first_q, first_d;
    logic             timeout_q, timeout_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [31:0]      seed_q, seed_d;
    logic             busy_q, cyc_q, we_q;
    logic [31:0]      adr_q;

    logic             lfsr_load_s, lfsr_step_s;
    logic [31:0]      lfsr_seed_s, lfsr_s;
    logic             req_s;

    mem_bist_lfsr u_lfsr (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .load_i  (lfsr_load_s),
        .seed_i  (lfsr_seed_s),
        .step_i  (lfsr_step_s),
        .value_o (lfsr_s)
    );

    // Next-state, counters, compare and LFSR control.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        err_d       = err_q;
        first_d     = first_q;
        timeout_d   = timeout_q;
        done_d      = done_q;
        pass_d      = pass_q;
        seed_d      = seed_q;
        lfsr_load_s = 1'b0;
        lfsr_step_s = 1'b0;
        lfsr_seed_s = seed_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    seed_d      = safe_seed(seed_i);
                    lfsr_seed_s = safe_seed(seed_i);
                    lfsr_load_s = 1'b1;
                    idx_d       = IDX_ZERO;
                    wait_d      = 16'h0000;
                    err_d       = 16'h0000;
                    first_d     = 32'h0000_0000;
                    timeout_d   = 1'b0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    state_d     = ST_WR_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_REQ, ST_RD_REQ: begin
                // An ack on the limit edge still counts as an ack.
                if (wbm_ack_i) begin
                    lfsr_step_s = 1'b1;
                    if ((state_q == ST_RD_REQ) && (wbm_dat_i != lfsr_s)) begin
                        err_d   = (err_q == 16'hFFFF) ? err_q : (err_q + 16'h0001);
                        first_d = (err_q == 16'h0000) ? adr_q : first_q;
                    end else begin
                        err_d = err_q;
                    end
                    state_d = (state_q == ST_WR_REQ) ? ST_WR_GAP : ST_RD_GAP;
                end else if (wait_q == WAIT_LIM) begin
                    timeout_d = 1'b1;
                    first_d   = (err_q == 16'h0000) ? adr_q : first_q;
                    state_d   = ST_FIN;
                end else begin
                    wait_d = wait_q + 16'h0001;
                end
            end
            ST_WR_GAP: begin
                wait_d = 16'h0000;
                if (idx_q == LAST_IDX) begin
                    lfsr_load_s = 1'b1;
                    idx_d       = IDX_ZERO;
                    state_d     = ST_RD_REQ;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = ST_WR_REQ;
                end
            end
            ST_RD_GAP: begin
                wait_d = 16'h0000;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = ST_RD_REQ;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                pass_d  = (err_q == 16'h0000) && !timeout_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_s = (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);

    // State, counters and registered bus/status outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= IDX_ZERO;
            wait_q    <= 16'h0000;
            err_q     <= 16'h0000;
            first_q   <= 32'h0000_0000;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            seed_q    <= 32'h0000_0000;
            busy_q    <= 1'b0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            first_q   <= first_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            seed_q    <= seed_d;
            busy_q    <= (state_d != ST_IDLE);
            cyc_q     <= req_s;
            we_q      <= (state_d == ST_WR_REQ);
            adr_q     <= req_s ? (BASE_ADR + (32'(idx_d) << 2)) : 32'h0000_0000;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign timeout_o       = timeout_q;
    assign err_cnt_o       = err_q;
    assign first_err_adr_o = first_q;
    assign wbm_adr_o       = adr_q;
    assign wbm_dat_o       = we_q ? lfsr_s : 32'h0000_0000;
    assign wbm_sel_o       = cyc_q ? 4'hF : 4'h0;
    assign wbm_we_o        = we_q;
    assign wbm_cyc_o       = cyc_q;
    assign wbm_stb_o       = cyc_q;

endmodule

// File: tb/tb_mem_bist_wb.sv
// Self-checking bench: SRAM slave models with fault injection and random ack
// latency, checked against a sequence-level reference of the self-test.
module tb_mem_bist_wb;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: WORDS=4, TIMEOUT=8
    logic        start_a = 1'b0;
    logic [31:0] seed_a  = 32'h0;
    logic        a_busy, a_done, a_pass, a_to;
    logic [15:0] a_err;
    logic [31:0] a_first, a_adr, a_dat;
    logic [3:0]  a_sel;
    logic        a_we, a_cyc, a_stb;
    logic        ack_a = 1'b0;
    logic [31:0] rdat_a = 32'h0;

    mem_bist_wb #(.BASE_ADR(BASE), .WORDS(4), .TIMEOUT(8)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_a), .seed_i(seed_a),
        .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .timeout_o(a_to),
        .err_cnt_o(a_err), .first_err_adr_o(a_first),
        .wbm_adr_o(a_adr), .wbm_dat_o(a_dat), .wbm_sel_o(a_sel), .wbm_we_o(a_we),
        .wbm_cyc_o(a_cyc), .wbm_stb_o(a_stb), .wbm_ack_i(ack_a), .wbm_dat_i(rdat_a)
    );

    // Instance B: WORDS=1
    logic        start_b = 1'b0;
    logic [31:0] seed_b  = 32'h0;
    logic        b_busy, b_done, b_pass, b_to;
    logic [15:0] b_err;
    logic [31:0] b_first, b_adr, b_dat;
    logic [3:0]  b_sel;
    logic        b_we, b_cyc, b_stb;
    logic        ack_b = 1'b0;
    logic [31:0] rdat_b = 32'h0;

    mem_bist_wb #(.BASE_ADR(BASE), .WORDS(1)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_b), .seed_i(seed_b),
        .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass), .timeout_o(b_to),
        .err_cnt_o(b_err), .first_err_adr_o(b_first),
        .wbm_adr_o(b_adr), .wbm_dat_o(b_dat), .wbm_sel_o(b_sel), .wbm_we_o(b_we),
        .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb), .wbm_ack_i(ack_b), .wbm_dat_i(rdat_b)
    );

    // Slave A: 4-word SRAM, random ack latency, per-word corruption of stored data.
    logic [31:0] mem_a  [4];
    logic [31:0] flip_a [4];
    logic        no_ack_a  = 1'b0;
    int          lat_max_a = 0;
    int          lat_a     = 0;
    int          cnt_a     = 0;
    int          proto_viol = 0;
    logic [31:0] off_a;
    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];
    logic        log_we[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_a <= 1'b0;
            cnt_a <= 0;
        end else begin
            if (a_cyc && a_stb && !ack_a && !no_ack_a) begin
                if (cnt_a >= lat_a) begin
                    ack_a <= 1'b1;
                    cnt_a <= 0;
                    lat_a <= $urandom_range(lat_max_a, 0);
                    off_a = a_adr - BASE;
                    if (a_we) mem_a[off_a[3:2]] <= a_dat ^ flip_a[off_a[3:2]];
                    else      rdat_a <= mem_a[off_a[3:2]];
                    log_adr.push_back(a_adr);
                    log_dat.push_back(a_dat);
                    log_we.push_back(a_we);
                end else begin
                    cnt_a <= cnt_a + 1;
                end
            end else begin
                ack_a <= 1'b0;
            end
            if ((a_cyc !== a_stb) || (a_cyc && a_sel !== 4'hF) || (!a_cyc && a_sel !== 4'h0))
                proto_viol <= proto_viol + 1;
        end
    end

    // Slave B: single-word SRAM acking one cycle after strobe.
    logic [31:0] mem_b = 32'h0;
    int wr_b = 0;
    int rd_b = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_b <= 1'b0;
        end else if (b_cyc && b_stb && !ack_b) begin
            ack_b <= 1'b1;
            if (b_we) begin mem_b <= b_dat; wr_b <= wr_b + 1; end
            else      begin rdat_b <= mem_b; rd_b <= rd_b + 1; end
        end else begin
            ack_b <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic pulse_start_a(input logic [31:0] s);
        @(negedge clk);
        start_a = 1'b1;
        seed_a  = s;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(output int cycles);
        cycles = 0;
        while (!a_done && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        if (!a_done) chk("done_wait", 32'(a_done), 32'h1);
    endtask

    // Full run on instance A against the reference model.
    task automatic run_a(input string tag, input logic [31:0] seed, input int lat_max,
                         input bit busy_start);
        logic [31:0] exp_dat [4];
        logic [31:0] v;
        int exp_errs;
        logic [31:0] exp_first;
        int cyc_n;
        log_adr.delete(); log_dat.delete(); log_we.delete();
        lat_max_a = lat_max;
        pulse_start_a(seed);
        chk({tag, "_busy"}, 32'(a_busy), 32'h1);
        if (busy_start) begin
            repeat (4) @(negedge clk);
            start_a = 1'b1;
            seed_a  = ~seed;
            @(negedge clk);
            start_a = 1'b0;
        end
        wait_done_a(cyc_n);
        v = (seed == 32'h0) ? 32'h1 : seed;
        for (int i = 0; i < 4; i++) begin
            exp_dat[i] = v;
            v = ref_step(v);
        end
        exp_errs  = 0;
        exp_first = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (flip_a[i] != 32'h0) begin
                if (exp_errs == 0) exp_first = BASE + 32'(4 * i);
                exp_errs++;
            end
        end
        chk({tag, "_n_acc"}, 32'(log_adr.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_adr.size(); i++) begin
            chk({tag, "_adr"}, log_adr[i], BASE + 32'(4 * (i % 4)));
            chk({tag, "_we"}, 32'(log_we[i]), (i < 4) ? 32'h1 : 32'h0);
            if (i < 4) chk({tag, "_wdat"}, log_dat[i], exp_dat[i]);
        end
        chk({tag, "_done"}, 32'(a_done), 32'h1);
        chk({tag, "_busy_end"}, 32'(a_busy), 32'h0);
        chk({tag, "_pass"}, 32'(a_pass), (exp_errs == 0) ? 32'h1 : 32'h0);
        chk({tag, "_err"}, 32'(a_err), 32'(exp_errs));
        chk({tag, "_first"}, a_first, exp_first);
        chk({tag, "_tmo"}, 32'(a_to), 32'h0);
    endtask

    initial begin
        int c;
        for (int i = 0; i < 4; i++) begin flip_a[i] = 32'h0; mem_a[i] = 32'h0; end
        repeat (3) @(negedge clk);
        chk("rst_cyc_in_rst", 32'(a_cyc), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(a_busy), 32'h0);
        chk("rst_done", 32'(a_done), 32'h0);
        chk("rst_pass", 32'(a_pass), 32'h0);
        chk("rst_err", 32'(a_err), 32'h0);
        chk("rst_first", a_first, 32'h0);
        chk("rst_bus", {a_adr[27:0], a_sel}, 32'h0);
        chk("rst_stb", 32'({a_cyc, a_stb, a_we}), 32'h0);

        run_a("basic", 32'h1234_5678, 0, 1'b0);

        flip_a[2] = 32'h0000_0001;
        run_a("flip2", 32'h1234_5678, 0, 1'b0);
        flip_a[2] = 32'h0;

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++)
                flip_a[i] = ($urandom_range(3, 0) == 0) ? (32'h1 << $urandom_range(31, 0)) : 32'h0;
            run_a("rand", $urandom, $urandom_range(2, 0), 1'b0);
        end
        for (int i = 0; i < 4; i++) flip_a[i] = 32'h0;

        run_a("seed0", 32'h0, 1, 1'b0);
        if (log_dat.size() > 0) chk("seed0_first_wdat", log_dat[0], 32'h0000_0001);

        run_a("busy_start", 32'hCAFE_F00D, 1, 1'b1);

        // Never-acking slave: cycle held for exactly TIMEOUT cycles.
        no_ack_a = 1'b1;
        pulse_start_a(32'hA5A5_0001);
        c = 1;
        for (int k = 0; k < 100 && !a_done; k++) begin
            @(negedge clk);
            if (a_cyc) c++;
        end
        chk("tmo_cyc_len", 32'(c), 32'd8);
        chk("tmo_done", 32'(a_done), 32'h1);
        chk("tmo_flag", 32'(a_to), 32'h1);
        chk("tmo_pass", 32'(a_pass), 32'h0);
        chk("tmo_first", a_first, BASE);
        chk("tmo_cyc_end", 32'(a_cyc), 32'h0);
        no_ack_a = 1'b0;

        // Reset in the middle of the write phase.
        pulse_start_a(32'h0BAD_BEEF);
        repeat (3) @(negedge clk);
        chk("mid_cyc_pre", 32'(a_busy), 32'h1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cyc", 32'({a_cyc, a_stb}), 32'h0);
        chk("mid_rst_busy", 32'(a_busy), 32'h0);
        chk("mid_rst_done", 32'(a_done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_done", 32'(a_done), 32'h0);
        chk("post_rst_cyc", 32'(a_cyc), 32'h0);

        // WORDS=1 instance: one write, one read, fixed latency.
        @(negedge clk);
        start_b = 1'b1;
        seed_b  = 32'h5555_AAAA;
        @(posedge clk);
        #1 start_b = 1'b0;
        c = 0;
        while (!b_done && c < 50) begin
            @(posedge clk);
            #1 c++;
        end
        chk("w1_latency", 32'(c), 32'd7);
        chk("w1_writes", 32'(wr_b), 32'd1);
        chk("w1_reads", 32'(rd_b), 32'd1);
        chk("w1_pass", 32'(b_pass), 32'h1);
        chk("w1_mem", mem_b, 32'h5555_AAAA);

        chk("proto_viol", 32'(proto_viol), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
